// File: rtl/handshake_const_check_pkg.sv
// Shared handshake constants: the constant-token literal used by both
// the producing source and this consuming checker.
package handshake_const_check_pkg;

  localparam logic [5:0] HS_CONST_TOKEN = 6'b010111;
  localparam int unsigned HS_DATA_W = 32;
  localparam int unsigned HS_CNT_W = 16;

endpackage

// File: rtl/handshake_const_check_reg_slice.sv
// One-slot forward register slice with a 1-bit payload; accepts a new
// token in the same cycle the held one drains (full throughput).
module handshake_reg_slice (
  input  logic clk,
  input  logic rst,
  input  logic in_data,
  input  logic in_valid,
  output logic in_ready,
  output logic out_data,
  output logic out_valid,
  input  logic out_ready
);

  logic valid_q, valid_d;
  logic data_q, data_d;
  logic in_fire;

  assign in_ready = !valid_q || out_ready;
  assign in_fire = in_valid && in_ready;

  always_comb begin
    valid_d = valid_q;
    data_d = data_q;
    if (in_fire) begin
      valid_d = 1'b1;
      data_d = in_data;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data = data_q;

endmodule

// File: rtl/handshake_const_check.sv
// Compares incoming tokens against a constant, emits a registered match
// flag, and keeps saturating match/mismatch statistics.
module handshake_const_check
  import handshake_const_check_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = HS_DATA_W,
  parameter logic [DATA_WIDTH-1:0] CONST_VALUE =
    DATA_WIDTH'(HS_CONST_TOKEN),
  parameter int unsigned CNT_WIDTH = HS_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] ins,
  input  logic                  ins_valid,
  output logic                  ins_ready,
  output logic                  ctrl_valid,
  input  logic                  ctrl_ready,
  output logic                  match,
  input  logic                  clr,
  output logic [CNT_WIDTH-1:0]  match_count,
  output logic [CNT_WIDTH-1:0]  mismatch_count
);

  logic hit;
  logic out_fire;
  logic [CNT_WIDTH-1:0] match_count_q, match_count_d;
  logic [CNT_WIDTH-1:0] mismatch_count_q, mismatch_count_d;

  assign hit = (ins == CONST_VALUE);

  handshake_reg_slice u_slice (
    .clk      (clk),
    .rst      (rst),
    .in_data  (hit),
    .in_valid (ins_valid),
    .in_ready (ins_ready),
    .out_data (match),
    .out_valid(ctrl_valid),
    .out_ready(ctrl_ready)
  );

  assign out_fire = ctrl_valid && ctrl_ready;

  // Counters saturate at all-ones; clr wins over a same-cycle increment.
  always_comb begin
    match_count_d = match_count_q;
    mismatch_count_d = mismatch_count_q;
    if (clr) begin
      match_count_d = '0;
      mismatch_count_d = '0;
    end else if (out_fire) begin
      if (match && (match_count_q != '1))
        match_count_d = match_count_q + CNT_WIDTH'(1);
      if (!match && (mismatch_count_q != '1))
        mismatch_count_d = mismatch_count_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      match_count_q <= '0;
      mismatch_count_q <= '0;
    end else begin
      match_count_q <= match_count_d;
      mismatch_count_q <= mismatch_count_d;
    end
  end

  assign match_count = match_count_q;
  assign mismatch_count = mismatch_count_q;

endmodule
